tri_screen_collector: RTL

Receives the stream of projected screen-space vertices produced by the projection pipeline (one vertex per valid cycle, three per triangle, in A/B/C order) and assembles them into packed 2D triangle records written to the triangle BRAM. It is the consumer of the projection stage and the producer of the BRAM contents that the rasterizer later reads. It frames each render pass between a start pulse and a last-vertex marker, counts the triangles it stores, and flags overflow and malformed frames.

---
 rtl/tri_pkg.sv | 25 ++
 rtl/screen_clamp.sv | 17 +
 rtl/tri_screen_collector.sv | 123 ++++++++++++
 3 files changed

// File: rtl/tri_pkg.sv
// Shared widths, saturation limits and types for the screen-space triangle collector.
package tri_pkg;

    localparam int X_W        = 11;
    localparam int Y_W        = 10;
    localparam int VERTEX2D_W = X_W + Y_W;
    localparam int TRI2D_W    = 3 * VERTEX2D_W;

    // Saturation limits, kept at 32 bits so they compare directly against raw screen coordinates
    localparam logic [31:0] X_MAX = 32'd1024;
    localparam logic [31:0] Y_MAX = 32'd720;

    // x sits in the low bits, so a packed vertex is {y[9:0], x[10:0]}
    typedef struct packed {
        logic [Y_W-1:0] y;
        logic [X_W-1:0] x;
    } vertex2d_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } collect_state_t;

endpackage

// File: rtl/screen_clamp.sv
// Saturates a 32-bit unsigned screen coordinate pair into a packed 2D vertex.
module screen_clamp
    import tri_pkg::*;
(
    input  logic [31:0] i_x,
    input  logic [31:0] i_y,
    output vertex2d_t   o_vtx
);

    // Values above the limit, including wrapped negatives, pin to the limit
    always_comb begin
        o_vtx   = '0;
        o_vtx.x = (i_x > X_MAX) ? X_MAX[X_W-1:0] : i_x[X_W-1:0];
        o_vtx.y = (i_y > Y_MAX) ? Y_MAX[Y_W-1:0] : i_y[Y_W-1:0];
    end

endmodule

// File: rtl/tri_screen_collector.sv
// Groups projected vertices into A/B/C triangles and writes packed records to BRAM.
module tri_screen_collector
    import tri_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_TRIS   = 1024
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  frame_start_in,
    input  logic                  vertex_valid_in,
    input  logic [31:0]           screen_x_in,
    input  logic [31:0]           screen_y_in,
    input  logic                  last_in,
    output logic                  bram_we_out,
    output logic [ADDR_WIDTH-1:0] bram_addr_out,
    output logic [TRI2D_W-1:0]    bram_data_out,
    output logic [ADDR_WIDTH:0]   tri_count_out,
    output logic                  frame_done_out,
    output logic                  busy_out,
    output logic                  overflow_out,
    output logic                  malformed_out
);

    localparam logic [ADDR_WIDTH:0] CNT_MAX = (ADDR_WIDTH + 1)'(MAX_TRIS);

    vertex2d_t w_vtx;

    collect_state_t        r_state;
    logic [1:0]            r_slot;
    vertex2d_t             r_va;
    vertex2d_t             r_vb;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [TRI2D_W-1:0]    r_data;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_done;
    logic                  r_busy;
    logic                  r_ovf;
    logic                  r_mal;

    screen_clamp u_clamp (
        .i_x   (screen_x_in),
        .i_y   (screen_y_in),
        .o_vtx (w_vtx)
    );

    // Frame FSM, vertex slotting and the registered BRAM write port
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= IDLE;
            r_slot  <= 2'd0;
            r_va    <= '0;
            r_vb    <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_count <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_ovf   <= 1'b0;
            r_mal   <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            if (frame_start_in) begin
                // A start always wins: any vertex this cycle is dropped and the frame restarts
                r_state <= COLLECT;
                r_busy  <= 1'b1;
                r_slot  <= 2'd0;
                r_addr  <= '0;
                r_count <= '0;
                r_ovf   <= 1'b0;
                r_mal   <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: ;
                    COLLECT: begin
                        if (vertex_valid_in) begin
                            case (r_slot)
                                2'd0: r_va <= w_vtx;
                                2'd1: r_vb <= w_vtx;
                                default: begin
                                    // C vertex: emit the triangle unless the frame is full
                                    if (r_count != CNT_MAX) begin
                                        r_we    <= 1'b1;
                                        r_addr  <= r_count[ADDR_WIDTH-1:0];
                                        r_data  <= {w_vtx, r_vb, r_va};
                                        r_count <= r_count + 1'b1;
                                    end else begin
                                        r_ovf <= 1'b1;
                                    end
                                end
                            endcase
                            if (last_in) begin
                                // A partial triangle at end of frame is discarded and flagged
                                r_state <= DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_slot  <= 2'd0;
                                if (r_slot != 2'd2) r_mal <= 1'b1;
                            end else begin
                                r_slot <= (r_slot == 2'd2) ? 2'd0 : r_slot + 2'd1;
                            end
                        end
                    end
                    DONE:    r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bram_we_out    = r_we;
    assign bram_addr_out  = r_addr;
    assign bram_data_out  = r_data;
    assign tri_count_out  = r_count;
    assign frame_done_out = r_done;
    assign busy_out       = r_busy;
    assign overflow_out   = r_ovf;
    assign malformed_out  = r_mal;

endmodule
